imsic_msi_sender: RTL and testbench



---
 rtl/imsic_msi_sender.sv | 188 ++++++++++++++++++
 tb/tb_imsic_msi_sender.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imsic_msi_sender.sv
// ============================================================================
// imsic_msi_sender
// ----------------------------------------------------------------------------
// Transmit end of the IMSIC MSI delivery link. Validated MSI write requests
// {hart, file, eid} are buffered in a small FIFO. Each one is then sent on a
// fixed-timing level-pulse link that has no acknowledge. The info word is
// loaded, msi_info_vld is held high for VLD_CYCLES cycles, and then the info
// word is held stable for HOLD_CYCLES more cycles. The receiver samples the
// info word on its synchronised falling edge of vld, so the hold window is
// what makes that sample safe.
//
// Ports
//   clk             block clock
//   rst             synchronous active-high reset
//   i_req_vld       request valid
//   o_req_rdy       request ready (FIFO not full, registered-count based)
//   i_req_hart      target hart
//   i_req_file      target interrupt file (0=M, 1=S, 2+ = VS)
//   i_req_eid       interrupt identity
//   o_msi_info      link info word, packed {hart, file, eid}
//   o_msi_info_vld  link valid level
//   o_busy          FIFO non-empty or link FSM not idle
//   o_drop_cnt      saturating count of rejected (malformed) requests
// ============================================================================
module imsic_msi_sender #(
    parameter int NR_HARTS        = 4,
    parameter int NR_HARTS_WIDTH  = 2,
    parameter int NR_INTP_FILES   = 7,
    parameter int NR_SRC          = 32,
    parameter int FIFO_DEPTH      = 4,
    parameter int VLD_CYCLES      = 4,
    parameter int HOLD_CYCLES     = 4,
    localparam int NR_SRC_WIDTH    = $clog2(NR_SRC),
    localparam int INTP_FILE_WIDTH = $clog2(NR_INTP_FILES),
    localparam int MSI_INFO_WIDTH  = NR_HARTS_WIDTH + INTP_FILE_WIDTH + NR_SRC_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_req_vld,
    output logic                       o_req_rdy,
    input  logic [NR_HARTS_WIDTH-1:0]  i_req_hart,
    input  logic [INTP_FILE_WIDTH-1:0] i_req_file,
    input  logic [NR_SRC_WIDTH-1:0]    i_req_eid,
    output logic [MSI_INFO_WIDTH-1:0]  o_msi_info,
    output logic                       o_msi_info_vld,
    output logic                       o_busy,
    output logic [7:0]                 o_drop_cnt
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int TMR_MAX = (VLD_CYCLES > HOLD_CYCLES) ? VLD_CYCLES : HOLD_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_HOLD
    } state_t;

    state_t                    state;
    logic [TMR_W-1:0]          tmr;

    logic [MSI_INFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [CNT_W-1:0]          count;

    logic                      accept;
    logic                      req_ok;
    logic                      push;
    logic                      pop;

    // The fields are compared at 32 bits. With the default parameters some
    // of the range limits fill the whole field, so at native width those
    // compares would be constant.
    logic [31:0] hart_ext;
    logic [31:0] file_ext;
    logic [31:0] eid_ext;

    assign hart_ext = 32'(i_req_hart);
    assign file_ext = 32'(i_req_file);
    assign eid_ext  = 32'(i_req_eid);

    assign req_ok = (eid_ext != 32'd0) &&
                    (eid_ext  < 32'(NR_SRC)) &&
                    (file_ext < 32'(NR_INTP_FILES)) &&
                    (hart_ext < 32'(NR_HARTS));

    // Ready comes only from the registered count. A pop in the full cycle
    // raises ready one cycle later; there is no bypass.
    assign o_req_rdy = (count != CNT_W'(FIFO_DEPTH));
    assign accept    = i_req_vld && o_req_rdy;
    // Malformed requests are consumed (handshake completes) but never stored.
    assign push      = accept && req_ok;
    assign pop       = (state == S_IDLE) && (count != '0);

    assign o_busy    = (count != '0) || (state != S_IDLE);

    // ------------------------------------------------------------------
    // FIFO storage
    // ------------------------------------------------------------------
    // NOTE: the storage array has no reset. Emptiness is tracked only by
    // count/pointers, so stale contents are never observed, and leaving the
    // array unreset lets it map onto plain registers or LUT-RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {i_req_hart, i_req_file, i_req_eid};
        end
    end

    // NOTE: all sequential state uses non-blocking assignments, so every
    // always_ff sees the values from before the edge no matter in which
    // order the simulator evaluates the blocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // FIFO_DEPTH is a power of two, so the pointers wrap naturally.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Drop counter (saturating)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            o_drop_cnt <= '0;
        end else if (accept && !req_ok && (o_drop_cnt != 8'hFF)) begin
            o_drop_cnt <= o_drop_cnt + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Link FSM: IDLE -> HIGH (VLD_CYCLES) -> HOLD (HOLD_CYCLES) -> IDLE
    // o_msi_info is loaded only on the pop edge and is otherwise frozen.
    // It stays stable through HOLD and keeps its last value in IDLE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            tmr            <= '0;
            o_msi_info     <= '0;
            o_msi_info_vld <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        o_msi_info     <= mem[rd_ptr];
                        o_msi_info_vld <= 1'b1;
                        tmr            <= TMR_W'(VLD_CYCLES - 1);
                        state          <= S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (tmr == '0) begin
                        o_msi_info_vld <= 1'b0;
                        tmr            <= TMR_W'(HOLD_CYCLES - 1);
                        state          <= S_HOLD;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (tmr == '0) begin
                        state <= S_IDLE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                default: begin
                    state          <= S_IDLE;
                    o_msi_info_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imsic_msi_sender.sv
// ============================================================================
// tb_imsic_msi_sender
// ----------------------------------------------------------------------------
// Self-checking bench for imsic_msi_sender with the default parameters
// (10-bit info word {hart[1:0], file[2:0], eid[4:0]}). It applies a table of
// single requests, then hand-written sequences for back-to-back traffic,
// a push on the cycle the FSM returns to IDLE, reset mid-pulse and
// drop-counter saturation. A receiver model synchronises vld with two flops
// and captures info on the synchronised falling edge.
// ============================================================================
module tb_imsic_msi_sender;

    localparam int HW = 2;
    localparam int FW = 3;
    localparam int EW = 5;
    localparam int IW = HW + FW + EW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_req_vld = 1'b0;
    logic          o_req_rdy;
    logic [HW-1:0] i_req_hart = '0;
    logic [FW-1:0] i_req_file = '0;
    logic [EW-1:0] i_req_eid  = '0;
    logic [IW-1:0] o_msi_info;
    logic          o_msi_info_vld;
    logic          o_busy;
    logic [7:0]    o_drop_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_drop = 0;

    imsic_msi_sender dut (
        .clk            (clk),
        .rst            (rst),
        .i_req_vld      (i_req_vld),
        .o_req_rdy      (o_req_rdy),
        .i_req_hart     (i_req_hart),
        .i_req_file     (i_req_file),
        .i_req_eid      (i_req_eid),
        .o_msi_info     (o_msi_info),
        .o_msi_info_vld (o_msi_info_vld),
        .o_busy         (o_busy),
        .o_drop_cnt     (o_drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Receiver model with EID_VLD_DLY=0. It captures on the synchronised
    // falling edge and ignores eid 0.
    logic          rx_s1 = 1'b0;
    logic          rx_s2 = 1'b0;
    logic          rx_s3 = 1'b0;
    logic          mon_prev = 1'b0;
    logic [IW-1:0] rx_q [$];
    logic [IW-1:0] exp_q [$];
    int            rise_q [$];

    always @(negedge clk) begin
        rx_s1 <= o_msi_info_vld;
        rx_s2 <= rx_s1;
        rx_s3 <= rx_s2;
        if (rx_s3 === 1'b1 && rx_s2 === 1'b0 && o_msi_info[EW-1:0] != '0)
            rx_q.push_back(o_msi_info);
        mon_prev <= o_msi_info_vld;
        if (o_msi_info_vld === 1'b1 && mon_prev === 1'b0)
            rise_q.push_back(cyc);
    end

    typedef struct {
        string         name;
        logic [HW-1:0] hart;
        logic [FW-1:0] file;
        logic [EW-1:0] eid;
        bit            ok;
        logic [IW-1:0] info;
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Holds one request for exactly one clock edge.
    task automatic drive_req(input logic [HW-1:0] h, input logic [FW-1:0] f, input logic [EW-1:0] e);
        i_req_vld  = 1'b1;
        i_req_hart = h;
        i_req_file = f;
        i_req_eid  = e;
        tick();
        i_req_vld  = 1'b0;
    endtask

    task automatic compare_rx(input string name);
        int n;
        check({name, "_rx_count"}, rx_q.size(), exp_q.size());
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check({name, "_rx_item"}, rx_q[i], exp_q[i]);
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic check_rises(input string name, input int n, input int first);
        check({name, "_rise_count"}, rise_q.size(), n);
        if (rise_q.size() == n) begin
            check({name, "_first_rise"}, rise_q[0], first);
            for (int i = 1; i < n; i++)
                check({name, "_rise_gap"}, rise_q[i] - rise_q[i-1], 9);
        end
        rise_q.delete();
    endtask

    initial begin : main
        int acc;
        logic [IW-1:0] w;

        // Hand-packed info words: {hart, file, eid}
        vecs[0] = '{"h2f1e5",   2'd2, 3'd1, 5'd5,  1'b1, 10'h225};
        vecs[1] = '{"h0f0e1",   2'd0, 3'd0, 5'd1,  1'b1, 10'h001};
        vecs[2] = '{"h3f6e31",  2'd3, 3'd6, 5'd31, 1'b1, 10'h3DF};
        vecs[3] = '{"h1f2e16",  2'd1, 3'd2, 5'd16, 1'b1, 10'h150};
        vecs[4] = '{"bad_eid0", 2'd3, 3'd0, 5'd0,  1'b0, 10'h000};
        vecs[5] = '{"bad_f7",   2'd0, 3'd7, 5'd3,  1'b0, 10'h000};
        vecs[6] = '{"bad_both", 2'd1, 3'd7, 5'd0,  1'b0, 10'h000};

        // ---------------- reset state ----------------
        repeat (3) tick();
        rst = 1'b0;
        check("rst_vld",  o_msi_info_vld, 0);
        check("rst_info", o_msi_info, 0);
        check("rst_busy", o_busy, 0);
        check("rst_drop", o_drop_cnt, 0);
        check("rst_rdy",  o_req_rdy, 1);
        tick();
        rx_q.delete();
        rise_q.delete();

        // ---------------- table of single requests ----------------
        foreach (vecs[v]) begin
            drive_req(vecs[v].hart, vecs[v].file, vecs[v].eid);
            if (vecs[v].ok) exp_q.push_back(vecs[v].info);
            else            exp_drop++;
            check({vecs[v].name, "_k0_vld"}, o_msi_info_vld, 0);
            check({vecs[v].name, "_k0_busy"}, o_busy, vecs[v].ok);
            for (int k = 1; k <= 8; k++) begin
                tick();
                check({vecs[v].name, "_vld"}, o_msi_info_vld, vecs[v].ok && k <= 4);
                if (vecs[v].ok) check({vecs[v].name, "_info"}, o_msi_info, vecs[v].info);
            end
            tick();
            check({vecs[v].name, "_idle_busy"}, o_busy, 0);
            check({vecs[v].name, "_drop"}, o_drop_cnt, exp_drop);
        end
        compare_rx("table");
        rise_q.delete();

        // ---------------- five back-to-back requests ----------------
        i_req_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            w = {HW'(i % 4), FW'(i), EW'(i + 1)};
            {i_req_hart, i_req_file, i_req_eid} = w;
            check("b2b_rdy_before", o_req_rdy, 1);
            exp_q.push_back(w);
            tick();
            if (i == 0) acc = cyc;
        end
        i_req_vld = 1'b0;
        check("b2b_full_rdy", o_req_rdy, 0);
        repeat (5) tick();
        check("b2b_still_full", o_req_rdy, 0);
        tick();
        check("b2b_rdy_after_pop", o_req_rdy, 1);
        repeat (50) tick();
        check("b2b_busy_end", o_busy, 0);
        check_rises("b2b", 5, acc + 1);
        compare_rx("b2b");

        // ---------------- push on the cycle FSM returns to IDLE ----------------
        drive_req(2'd1, 3'd3, 5'd7);              // A at edge t0
        acc = cyc;
        drive_req(2'd2, 3'd4, 5'd9);              // B queued at t1 while A pops
        repeat (7) tick();                        // edges t2..t8
        check("ret_state_busy", o_busy, 1);
        drive_req(2'd3, 3'd5, 5'd11);             // C at t9, HOLD->IDLE edge
        exp_q.push_back({2'd1, 3'd3, 5'd7});
        exp_q.push_back({2'd2, 3'd4, 5'd9});
        exp_q.push_back({2'd3, 3'd5, 5'd11});
        tick();                                   // t10: B pops
        check("ret_b_info", o_msi_info, {2'd2, 3'd4, 5'd9});
        repeat (40) tick();
        check("ret_busy_end", o_busy, 0);
        check("ret_rdy_end", o_req_rdy, 1);
        check_rises("ret", 3, acc + 1);
        compare_rx("ret");

        // ---------------- reset during HIGH with 2 queued ----------------
        drive_req(2'd0, 3'd1, 5'd2);
        drive_req(2'd1, 3'd1, 5'd3);
        drive_req(2'd2, 3'd1, 5'd4);
        tick();
        check("rmid_pre_vld", o_msi_info_vld, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_drop = 0;
        check("rmid_vld",  o_msi_info_vld, 0);
        check("rmid_info", o_msi_info, 0);
        check("rmid_busy", o_busy, 0);
        check("rmid_rdy",  o_req_rdy, 1);
        check("rmid_drop", o_drop_cnt, exp_drop);
        rise_q.delete();
        rx_q.delete();
        repeat (30) tick();
        check("rmid_no_rise", rise_q.size(), 0);
        compare_rx("rmid");

        // ---------------- drop counter saturation ----------------
        i_req_vld  = 1'b1;
        i_req_hart = 2'd0;
        i_req_file = 3'd0;
        i_req_eid  = 5'd0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 253) check("sat_254", o_drop_cnt, 254);
        end
        i_req_vld = 1'b0;
        check("sat_255",  o_drop_cnt, 255);
        check("sat_busy", o_busy, 0);
        check("sat_rdy",  o_req_rdy, 1);
        repeat (12) tick();
        check("sat_no_rise", rise_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
